regfile_param: RTL
==================

# regfile_param

Parametrised successor to the 32×64 register file: configurable data width, register count and hardwired-zero index. It adds optional same-cycle write-to-read bypass, asynchronous reset of every register and a sequenced bulk-clear engine with a busy/done handshake. It sits in the decode stage of the pipelined CPU, providing two combinational read ports and one clocked write port to the datapath.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 31, index hardwired to zero; value NUM_REGS disables the zero register
- BYPASS, 1, 1 = write data forwarded to matching read port in the same cycle; 0 = reads see stored value only
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers and the FSM
- ReadRegister1  input  ADDR_W  read port 1 index
- ReadRegister2  input  ADDR_W  read port 2 index
- ReadData1  output  DATA_W  read port 1 data, combinational
- ReadData2  output  DATA_W  read port 2 data, combinational
- WriteRegister  input  ADDR_W  write index
- WriteData  input  DATA_W  write data
- RegWrite  input  1  write enable
- ClearReq  input  1  request bulk clear; sampled in IDLE only
- Busy  output  1  high while the clear sweep is in progress
- ClearDone  output  1  one-cycle pulse after the sweep completes

## Operation
- Storage is NUM_REGS × DATA_W flops.
- Write: on a rising edge with RegWrite=1, Busy=0 and WriteRegister≠ZERO_REG, reg[WriteRegister] ← WriteData.
- Writes to ZERO_REG are discarded. Writes while Busy=1 are discarded with no error flag.
- Read N: if ReadRegisterN==ZERO_REG, ReadDataN=0.
- Otherwise, if BYPASS=1, RegWrite=1, Busy=0 and WriteRegister==ReadRegisterN, ReadDataN=WriteData.
- Otherwise, ReadDataN=reg[ReadRegisterN].
- Both read ports are independent. Both ports may address the same register.
- FSM has two states: IDLE and CLEAR.
- IDLE → CLEAR on a rising edge with ClearReq=1. The sweep counter loads 0.
- In CLEAR, each edge writes reg[cnt] ← 0 and increments cnt.
- The edge at which cnt==NUM_REGS-1 performs the final write and returns the FSM to IDLE. ClearDone is registered high for the following cycle.
- ClearReq is ignored in CLEAR. ClearReq held high in IDLE starts a new sweep on every entry to IDLE. This includes the cycle in which ClearDone is high.
- The counter is ADDR_W bits wide and never wraps inside a sweep.
- Reset is asynchronous and active-high:
  - all registers go to 0
  - FSM goes to IDLE, cnt goes to 0
  - Busy=0, ClearDone=0
- Reset mid-sweep aborts the sweep. No ClearDone is produced.

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible through storage on the cycle after its edge. With BYPASS=1 it is also visible in the cycle it is presented.
- Busy is registered. It rises the cycle after ClearReq is sampled and stays high for exactly NUM_REGS cycles.
- ClearDone is high for 1 cycle, coincident with the first cycle of Busy=0 after the sweep.
- Sweep length is NUM_REGS edges. Request to done is NUM_REGS+1 cycles.
- After reset deassertion, the first write can occur on the next rising edge.

## Test plan
- Reset then read all: assert reset mid-run with nonzero contents → every ReadData1/2 = 0, Busy=0, ClearDone=0 immediately, without waiting for a clock edge.
- Write/read and zero register: write 0xDEADBEEF_CAFEF00D to reg 5, then 0x1234 to reg 31 → next cycle reg 5 reads the written value on both ports; reg 31 reads 0.
- Bypass: BYPASS=1, RegWrite=1, WriteRegister=7, WriteData=0xAA, ReadRegister1=7 → ReadData1=0xAA in the same cycle. With BYPASS=0 → the old value until the next cycle.
- Bulk clear: fill regs 0–30 with their index, pulse ClearReq → Busy high 32 cycles, ClearDone pulses once at cycle 33, all regs read 0. A write to reg 3 issued mid-sweep is discarded.
- Reset mid-sweep: ClearReq, then reset at cycle 10 → Busy=0 immediately, all regs 0, no ClearDone. The next ClearReq runs a full 32-cycle sweep.
- Parametrisation: DATA_W=32, ADDR_W=3, ZERO_REG=8 → all 8 registers writable, sweep takes 8 cycles, bypass still correct.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register-file bus: two read ports, one write port and the bulk-clear handshake.
interface regfile_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [DATA_W-1:0] ReadData1, ReadData2, WriteData;
  logic              RegWrite, ClearReq, Busy, ClearDone;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, ClearReq,
    input  ReadData1, ReadData2, Busy, ClearDone
  );
  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, ClearReq,
    output ReadData1, ReadData2, Busy, ClearDone
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised decode-stage register file: 2 combinational read ports, 1 write port,
// optional write->read bypass and a sequenced bulk-clear sweep with busy/done handshake.
module regfile_param_rdport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                ra,
  input  logic [ADDR_W-1:0]                wa,
  input  logic [DATA_W-1:0]                wd,
  input  logic                             byp_en,
  output logic [DATA_W-1:0]                rd
);
  always_comb begin
    rd = regs[ra];
    if (int'(ra) == ZERO_REG)                    rd = '0;
    else if (BYPASS != 0 && byp_en && wa == ra)  rd = wd;
  end
endmodule

module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus
);
  localparam int NUM_REGS  = 2**ADDR_W;
  localparam int NUM_PORTS = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                          state, state_nxt;
  logic [ADDR_W-1:0]               cnt, cnt_nxt;
  logic                            done, done_nxt, clr_we;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            busy, we, byp_en;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] ra;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd;

  assign busy   = (state == CLEAR);
  assign byp_en = bus.RegWrite && !busy;
  assign we     = byp_en && (int'(bus.WriteRegister) != ZERO_REG);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      IDLE: if (bus.ClearReq) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        clr_we = 1'b1;
        // last index written on this edge; counter never wraps inside a sweep
        if (&cnt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      regs  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (clr_we)  regs[cnt]               <= '0;
      else if (we) regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  assign ra = {bus.ReadRegister2, bus.ReadRegister1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_param_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .regs  (regs),
      .ra    (ra[p]),
      .wa    (bus.WriteRegister),
      .wd    (bus.WriteData),
      .byp_en(byp_en),
      .rd    (rd[p])
    );
  end

  assign bus.ReadData1 = rd[0];
  assign bus.ReadData2 = rd[1];
  assign bus.Busy      = busy;
  assign bus.ClearDone = done;
endmodule
